// File: rtl/dlatch_bank_ctrl.sv
// rtl/dlatch_bank_ctrl.sv - write/clear sequencer and round-robin arbiter for a bank of reset-able D latches
module dlatch_bank_ctrl #(
  parameter  int WIRE  = 8,
  parameter  int DEPTH = 4,
  parameter  int REQ   = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQ-1:0]      req,
  input  logic [REQ*AW-1:0]   addr,
  input  logic [REQ*WIRE-1:0] wdata,
  input  logic                clr,
  output logic [REQ-1:0]      gnt,
  output logic                err,
  output logic                clr_done,
  output logic                busy,
  output logic [WIRE-1:0]     lat_data,
  output logic [DEPTH-1:0]    lat_en,
  output logic                lat_rst
);

  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLR} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     winner_q, winner_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIRE-1:0]   wdata_q, wdata_d;
  logic [REQ-1:0]    gnt_q, gnt_d;
  logic              err_q, err_d;
  logic              clr_done_q, clr_done_d;
  logic              busy_q, busy_d;
  logic [WIRE-1:0]   lat_data_q, lat_data_d;
  logic [DEPTH-1:0]  lat_en_q, lat_en_d;
  logic              lat_rst_q, lat_rst_d;

  logic              found;
  logic [PW-1:0]     pick;
  int                idx;

  // Next state, arbitration and capture of the winning requester's slice
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    found    = 1'b0;
    pick     = rr_q;
    idx      = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= REQ) idx = idx - REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLR;
        end else if (found) begin
          state_d  = SETUP;
          winner_d = pick;
          addr_d   = addr[int'(pick)*AW +: AW];
          wdata_d  = wdata[int'(pick)*WIRE +: WIRE];
        end
      end
      SETUP: state_d = OPEN;
      OPEN:  state_d = HOLD;
      HOLD: begin
        state_d = IDLE;
        rr_d    = (int'(winner_q) == REQ - 1) ? '0 : PW'(int'(winner_q) + 1);
      end
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every port is a flop
  always_comb begin
    gnt_d      = '0;
    err_d      = 1'b0;
    clr_done_d = 1'b0;
    lat_rst_d  = 1'b0;
    lat_en_d   = '0;
    lat_data_d = lat_data_q;
    busy_d     = (state_d != IDLE);
    case (state_d)
      SETUP: lat_data_d = wdata_d;
      OPEN: begin
        for (int i = 0; i < DEPTH; i++) lat_en_d[i] = (addr_q == AW'(i));
      end
      HOLD: begin
        for (int i = 0; i < REQ; i++) gnt_d[i] = (winner_q == PW'(i));
        err_d = ({1'b0, addr_q} >= DEPTH_W);
      end
      CLR: begin
        lat_rst_d  = 1'b1;
        clr_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      winner_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      lat_data_q <= '0;
      lat_en_q   <= '0;
      lat_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      winner_q   <= winner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      lat_data_q <= lat_data_d;
      lat_en_q   <= lat_en_d;
      lat_rst_q  <= lat_rst_d;
    end
  end

  assign gnt      = gnt_q;
  assign err      = err_q;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
  assign lat_data = lat_data_q;
  assign lat_en   = lat_en_q;
  assign lat_rst  = lat_rst_q;

endmodule

// File: tb/tb_dlatch_bank_ctrl.sv
// tb/tb_dlatch_bank_ctrl.sv - self-checking bench for dlatch_bank_ctrl
module tb_dlatch_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [1:0]  req = '0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;

  logic [1:0]  gnt;
  logic        err, clr_done, busy, lat_rst;
  logic [7:0]  lat_data;
  logic [3:0]  lat_en;

  logic [1:0]  gnt3;
  logic        err3, clr_done3, busy3, lat_rst3;
  logic [7:0]  lat_data3;
  logic [2:0]  lat_en3;

  dlatch_bank_ctrl #(.WIRE(8), .DEPTH(4), .REQ(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .clr(clr),
    .gnt(gnt), .err(err), .clr_done(clr_done), .busy(busy),
    .lat_data(lat_data), .lat_en(lat_en), .lat_rst(lat_rst)
  );

  dlatch_bank_ctrl #(.WIRE(8), .DEPTH(3), .REQ(2)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .clr(clr),
    .gnt(gnt3), .err(err3), .clr_done(clr_done3), .busy(busy3),
    .lat_data(lat_data3), .lat_en(lat_en3), .lat_rst(lat_rst3)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] gnt;
    logic       err;
    logic       cd;
    logic       busy;
    logic       lrst;
    logic [7:0] data;
    logic [3:0] en;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] req;
    logic [1:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt;
    logic       err;
    logic [3:0] en;
    logic [7:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_tab[6];
  int   checks = 0;
  int   failures = 0;

  function automatic wr_t mk_wr(string n, logic [1:0] r, logic [1:0] a0, logic [1:0] a1,
                                logic [7:0] d0, logic [7:0] d1, logic [1:0] g, logic e,
                                logic [3:0] en, logic [7:0] data);
    wr_t v;
    v.name = n; v.req = r; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.err = e; v.en = en; v.data = data;
    return v;
  endfunction

  function automatic void push(string n, logic [1:0] g, logic e, logic cd, logic b,
                               logic lr, logic [7:0] d, logic [3:0] en);
    exp_t x;
    x.name = n; x.gnt = g; x.err = e; x.cd = cd; x.busy = b; x.lrst = lr; x.data = d; x.en = en;
    exp_q.push_back(x);
  endfunction

  task automatic cyc();
    exp_t x;
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(lat_en) || (lat_rst && (|lat_en))) begin
      failures++;
      $display("FAIL en_rst_excl: lat_en=%b lat_rst=%b, required one-hot-or-zero and exclusive", lat_en, lat_rst);
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({gnt, err, clr_done, busy, lat_rst, lat_data, lat_en} !==
          {x.gnt, x.err, x.cd, x.busy, x.lrst, x.data, x.en}) begin
        failures++;
        $display("FAIL %s: got gnt=%b err=%b clr_done=%b busy=%b lat_rst=%b lat_data=%h lat_en=%b; required gnt=%b err=%b clr_done=%b busy=%b lat_rst=%b lat_data=%h lat_en=%b",
                 x.name, gnt, err, clr_done, busy, lat_rst, lat_data, lat_en,
                 x.gnt, x.err, x.cd, x.busy, x.lrst, x.data, x.en);
      end
    end
  endtask

  task automatic chk3(string n, logic [1:0] g, logic e, logic b, logic [7:0] d, logic [2:0] en);
    checks++;
    if ({gnt3, err3, clr_done3, busy3, lat_rst3, lat_data3, lat_en3} !== {g, e, 1'b0, b, 1'b0, d, en}) begin
      failures++;
      $display("FAIL %s: got gnt=%b err=%b clr_done=%b busy=%b lat_rst=%b lat_data=%h lat_en=%b; required gnt=%b err=%b clr_done=0 busy=%b lat_rst=0 lat_data=%h lat_en=%b",
               n, gnt3, err3, clr_done3, busy3, lat_rst3, lat_data3, lat_en3, g, e, b, d, en);
    end
  endtask

  task automatic do_write(input wr_t v);
    req   = v.req;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    push({v.name, "_setup"}, 2'b00, 1'b0,  1'b0, 1'b1, 1'b0, v.data, 4'b0000);
    push({v.name, "_open"},  2'b00, 1'b0,  1'b0, 1'b1, 1'b0, v.data, v.en);
    push({v.name, "_hold"},  v.gnt, v.err, 1'b0, 1'b1, 1'b0, v.data, 4'b0000);
    push({v.name, "_idle"},  2'b00, 1'b0,  1'b0, 1'b0, 1'b0, v.data, 4'b0000);
    cyc();
    req = 2'b00;
    cyc(); cyc(); cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_tab[0] = mk_wr("wr_a5",    2'b01, 2'd2, 2'd0, 8'hA5, 8'h00, 2'b01, 1'b0, 4'b0100, 8'hA5);
    wr_tab[1] = mk_wr("wr_r1",    2'b10, 2'd0, 2'd0, 8'h00, 8'h3C, 2'b10, 1'b0, 4'b0001, 8'h3C);
    wr_tab[2] = mk_wr("wr_both0", 2'b11, 2'd3, 2'd1, 8'h5A, 8'hC3, 2'b01, 1'b0, 4'b1000, 8'h5A);
    wr_tab[3] = mk_wr("wr_both1", 2'b11, 2'd3, 2'd1, 8'h5A, 8'hC3, 2'b10, 1'b0, 4'b0010, 8'hC3);
    wr_tab[4] = mk_wr("wr_r1b",   2'b10, 2'd0, 2'd2, 8'h00, 8'hFF, 2'b10, 1'b0, 4'b0100, 8'hFF);
    wr_tab[5] = mk_wr("wr_zero",  2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 2'b01, 1'b0, 4'b0001, 8'h00);

    // reset held two cycles, then released
    push("rst0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000);
    push("rst1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000);
    cyc(); cyc();
    rst = 1'b0;
    push("rst_rel", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
    cyc();

    // both requesters held high: grants alternate starting at requester 0
    req   = 2'b11;
    addr  = {2'd3, 2'd1};
    wdata = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = k[0];
      push("rr_setup", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, w ? 8'h22 : 8'h11, 4'b0000);
      push("rr_open",  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, w ? 8'h22 : 8'h11, w ? 4'b1000 : 4'b0010);
      push("rr_hold",  w ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, w ? 8'h22 : 8'h11, 4'b0000);
      push("rr_idle",  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, w ? 8'h22 : 8'h11, 4'b0000);
    end
    for (int k = 0; k < 16; k++) cyc();
    req = 2'b00;

    for (int i = 0; i < 6; i++) do_write(wr_tab[i]);

    // clear and request together: clear wins, write follows
    clr = 1'b1; req = 2'b01; addr = {2'd0, 2'd1}; wdata = {8'h00, 8'h77};
    push("clrw_clr",   2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'b0000);
    push("clrw_idle",  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
    push("clrw_setup", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 4'b0000);
    push("clrw_open",  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 4'b0010);
    push("clrw_hold",  2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 4'b0000);
    push("clrw_end",   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 4'b0000);
    cyc();
    clr = 1'b0;
    cyc(); cyc();
    req = 2'b00;
    cyc(); cyc(); cyc();

    // clear arriving mid-write waits for the write to finish
    req = 2'b10; addr = {2'd2, 2'd0}; wdata = {8'h4B, 8'h00};
    push("midclr_setup", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 4'b0000);
    push("midclr_open",  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 4'b0100);
    push("midclr_hold",  2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 4'b0000);
    push("midclr_idle",  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 4'b0000);
    push("midclr_clr",   2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4B, 4'b0000);
    push("midclr_end",   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, 4'b0000);
    cyc();
    req = 2'b00; clr = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    clr = 1'b0;
    cyc();

    // address 3 is in range for DEPTH=4 and out of range for DEPTH=3
    req = 2'b01; addr = {2'd0, 2'd3}; wdata = {8'h00, 8'hE7};
    push("oor4_setup", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE7, 4'b0000);
    push("oor4_open",  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE7, 4'b1000);
    push("oor4_hold",  2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE7, 4'b0000);
    push("oor4_idle",  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE7, 4'b0000);
    cyc(); chk3("oor3_setup", 2'b00, 1'b0, 1'b1, 8'hE7, 3'b000);
    req = 2'b00;
    cyc(); chk3("oor3_open",  2'b00, 1'b0, 1'b1, 8'hE7, 3'b000);
    cyc(); chk3("oor3_hold",  2'b01, 1'b1, 1'b1, 8'hE7, 3'b000);
    cyc(); chk3("oor3_idle",  2'b00, 1'b0, 1'b0, 8'hE7, 3'b000);

    // reset during OPEN aborts the write without a grant
    req = 2'b01; addr = {2'd0, 2'd1}; wdata = {8'h00, 8'h99};
    push("abort_setup", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 4'b0000);
    push("abort_open",  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 4'b0010);
    push("abort_rst",   2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000);
    push("abort_rel",   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
    push("abort_quiet", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
    push("abort_quiet", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
    cyc();
    req = 2'b00;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
